// File: rtl/mw_writeback_drain.sv
// Writeback drain: queues execute results in an in-order FIFO and commits them
// to the scratchpad write port when granted, with store-to-load forwarding.
module mw_writeback_drain #(
  parameter int N     = 8,
  parameter int A     = 10,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  res_in,
  input  logic          wen_in,
  input  logic [A-1:0]  dest_in,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [A-1:0]  mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [A-1:0]  rd_addr,
  output logic          fwd_hit,
  output logic [N-1:0]  fwd_data,
  output logic          stall,
  output logic          overflow,
  output logic [CW-1:0] count
);

  logic [A-1:0]  addr_q [DEPTH];
  logic [N-1:0]  data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic full, empty, push, pop;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    pop        = !empty && mem_ready;
    // A pop in the same edge frees the slot, so a push at full is still taken.
    push       = wen_in && (!full || pop);
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (wen_in && !push) overflow_d = 1'b1;
  end

  // NOTE: the payload array carries no reset; occupancy (count) alone decides
  // which entries are live, so clearing the pointers invalidates everything.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= dest_in;
      data_q[tail_q] <= res_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    mem_we    = !empty;
    mem_addr  = empty ? '0 : addr_q[head_q];
    mem_wdata = empty ? '0 : data_q[head_q];
  end

  // Scan oldest to youngest; later matches overwrite so the youngest wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // One slot of headroom absorbs the request already in the pipeline register.
  assign stall    = (count_q >= CW'(DEPTH - 1));
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_mw_writeback_drain.sv
// Scoreboarded bench for mw_writeback_drain: directed pushes queue expected
// scratchpad writes; a monitor compares each committed write in order.
module tb_mw_writeback_drain;

  localparam int N = 8, A = 10, DEPTH = 4, CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  res_in;
  logic          wen_in;
  logic [A-1:0]  dest_in;
  logic          mem_ready;
  logic          mem_we;
  logic [A-1:0]  mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [A-1:0]  rd_addr;
  logic          fwd_hit;
  logic [N-1:0]  fwd_data;
  logic          stall;
  logic          overflow;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [N-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;

  mw_writeback_drain #(.N(N), .A(A), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .res_in(res_in), .wen_in(wen_in),
    .dest_in(dest_in), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rd_addr(rd_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall(stall),
    .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a write commits at the edge after a negedge with mem_we && mem_ready.
  always @(negedge clock) begin
    if (mon_en && mem_we === 1'b1 && mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one push for the next edge; 'accept' records the hand-computed outcome.
  task automatic push(input logic [N-1:0] d, input logic [A-1:0] a,
                      input bit accept);
    wen_in  = 1'b1;
    res_in  = d;
    dest_in = a;
    if (accept) exp_q.push_back('{addr: a, data: d});
    tick();
    wen_in  = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    wen_in    = 1'b1;
    res_in    = 8'h77;
    dest_in   = 10'h007;
    mem_ready = 1'b0;
    rd_addr   = 10'h007;
    tick();
    tick();
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_stall",     32'(stall),     32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_fwd_hit",   32'(fwd_hit),   32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset  = 1'b1;
    wen_in = 1'b0;
    mon_en = 1'b1;

    // Pass-through: one cycle of latency, then drained.
    mem_ready = 1'b1;
    push(8'h5A, 10'h012, 1'b1);
    check("pt_mem_we",   32'(mem_we),    32'd1);
    check("pt_addr",     32'(mem_addr),  32'h012);
    check("pt_wdata",    32'(mem_wdata), 32'h5A);
    tick();
    check("pt_count",    32'(count),  32'd0);
    check("pt_mem_we_0", 32'(mem_we), 32'd0);

    // Back-pressure and overflow.
    mem_ready = 1'b0;
    push(8'h11, 10'h001, 1'b1);
    check("bp_count1", 32'(count), 32'd1);
    check("bp_stall1", 32'(stall), 32'd0);
    push(8'h22, 10'h002, 1'b1);
    check("bp_stall2", 32'(stall), 32'd0);
    push(8'h33, 10'h003, 1'b1);
    check("bp_count3", 32'(count), 32'd3);
    check("bp_stall3", 32'(stall), 32'd1);
    check("bp_ovf3",   32'(overflow), 32'd0);
    push(8'h44, 10'h004, 1'b1);
    check("bp_count4", 32'(count), 32'd4);
    push(8'h55, 10'h005, 1'b0);
    check("bp_count_drop", 32'(count), 32'd4);
    check("bp_overflow",   32'(overflow), 32'd1);
    rd_addr = 10'h002;
    #1;
    check("bp_fwd_hit",  32'(fwd_hit),  32'd1);
    check("bp_fwd_data", 32'(fwd_data), 32'h22);
    rd_addr = 10'h005;
    #1;
    check("bp_fwd_dropped", 32'(fwd_hit), 32'd0);

    // Simultaneous push and pop at full.
    mem_ready = 1'b1;
    push(8'h66, 10'h006, 1'b1);
    check("full_both_count", 32'(count),    32'd4);
    check("full_both_head",  32'(mem_addr), 32'h002);
    repeat (4) tick();
    check("drain_count",    32'(count),    32'd0);
    check("drain_overflow", 32'(overflow), 32'd1);

    // Forwarding: youngest of duplicate addresses wins.
    mem_ready = 1'b0;
    push(8'hAA, 10'h3FF, 1'b1);
    push(8'hBB, 10'h3FF, 1'b1);
    rd_addr = 10'h3FF;
    #1;
    check("fwd_hit",  32'(fwd_hit),  32'd1);
    check("fwd_data", 32'(fwd_data), 32'hBB);
    rd_addr = 10'h000;
    #1;
    check("fwd_miss_hit",  32'(fwd_hit),  32'd0);
    check("fwd_miss_data", 32'(fwd_data), 32'h00);
    mem_ready = 1'b1;
    rd_addr   = 10'h3FF;
    #1;
    check("fwd_popping_still_hit", 32'(fwd_data), 32'hBB);
    repeat (2) tick();
    check("fwd_drain_count", 32'(count), 32'd0);

    // Reset mid-drain: the head write at the reset edge happens, rest discarded.
    mem_ready = 1'b0;
    push(8'h01, 10'h100, 1'b1);
    push(8'h02, 10'h101, 1'b0);
    push(8'h03, 10'h102, 1'b0);
    check("mid_count3", 32'(count), 32'd3);
    mem_ready = 1'b1;
    reset     = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_mem_we",   32'(mem_we),   32'd0);
    check("mid_count",    32'(count),    32'd0);
    check("mid_overflow", 32'(overflow), 32'd0);
    repeat (3) tick();
    check("mid_no_writes", 32'(count), 32'd0);

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
